timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Programmable multi-channel timer scheduler on the LPC clock domain. It consumes the slow-clock periodic strobes (1 ms, 16 ms, 125 ms, 1 s), synchronizes them, and shares a single decrement unit across `NUM_CH` software-configured channels in a sequential sweep. Each channel raises a one-cycle `Expire` pulse when its count elapses. The block sits beside the strobe generator and serves LED blink, watchdog and power-sequencing timeouts.

## Interface
- `NUM_CH`, default 4: number of timer channels (2..16).
- `CNT_W`, default 8: reload/count width in ticks.

Ports:
- `LpcClock` in 1: 33 MHz LPC clock. This is the only clock.
- `ResetN` in 1: asynchronous, active-low reset.
- `Strobe1ms` in 1: SlowClock-domain pulse, one SlowClock cycle wide. Asynchronous to `LpcClock`.
- `Strobe16ms` in 1: as above.
- `Strobe125ms` in 1: as above.
- `Strobe1s` in 1: as above.
- `CfgWr` in 1: single-cycle channel configuration write strobe.
- `CfgAddr` in `$clog2(NUM_CH)`: channel index for the write.
- `CfgData` in `CNT_W+4`, with fields:
  - [CNT_W+3] Enable
  - [CNT_W+2] Periodic
  - [CNT_W+1:CNT_W] Src
  - [CNT_W-1:0] Reload
- `Expire` out `NUM_CH`: one-`LpcClock` pulse per channel expiry.
- `Running` out `NUM_CH`: the channel is armed and counting.

## Operation
- **Tick detection:** each strobe passes through a 2-flop synchronizer, then a registered rising-edge detect. Each detected edge sets `Pending[src]`.
- **Src encoding:** 0 = 1 ms, 1 = 16 ms, 2 = 125 ms, 3 = 1 s.
- **FSM states:**
  - IDLE → SWEEP when `Pending != 0`. On that transition: `ActiveSrc <= Pending`, `Pending` is cleared, `ChIdx <= 0`.
  - SWEEP: one channel is processed per cycle, then `ChIdx++`. When `ChIdx == NUM_CH-1`, the next state is IDLE.
- **Channel visit:** applies when `Running[ChIdx]` and `ActiveSrc[Src[ChIdx]]` are both set.
  - If `Count == 1`: assert `Expire[ChIdx]` on the next cycle. If Periodic, `Count <= Reload`. Otherwise `Running <= 0`.
  - Otherwise: `Count <= Count - 1`.
- **Config write:**
  - Enable = 1 with Reload ≠ 0: latch the fields, `Count <= Reload`, `Running <= 1`.
  - Enable = 0 or Reload = 0: `Running <= 0`, and no `Expire` is generated.
- **Arithmetic:** `Count` is unsigned `CNT_W` bits and never decrements below 1 while running, so it cannot wrap.
- **Boundary conditions:**
  - CfgWr to the channel being visited in the same cycle: CfgWr wins and the decrement is discarded.
  - Edge detected in the same cycle `Pending` is captured: it stays in `Pending` for the next sweep and is not lost.
  - The same source ticks again before its pending bit is serviced: the ticks merge. This cannot occur in practice, because strobes are ≥488 µs apart and a sweep lasts `NUM_CH` cycles.
  - Several sources active in one sweep: each channel is decremented at most once per sweep.
  - `ResetN` low mid-sweep: everything returns to reset values immediately, and any pending ticks are dropped.
- **Reset values:** `Expire = 0`, `Running = 0`, all `Count`/`Reload`/config fields = 0, `Pending = 0`, sync flops = 0, state IDLE, `ChIdx = 0`.

## Timing
- Strobe high before `LpcClock` edge k: sync at k and k+1, edge registered into `Pending` at k+2, SWEEP entered at k+3.
- Channel i is visited at k+3+i. Its `Expire[i]` is high during cycle k+4+i for exactly one cycle.
- CfgWr at edge j: `Running` high after j. The first decrement occurs on the first sweep that starts after j.
- A sweep lasts exactly `NUM_CH` cycles, with one idle cycle minimum between sweeps.

## Structure
- Package `timer_sched_pkg` holds:
  - SRC_* encoding constants.
  - State enum {IDLE, SWEEP}.
  - CfgData field offset functions of `CNT_W`.
- Sub-module `strobe_sync`: 2-flop synchronizer plus edge-detect flop with a one-cycle tick output. It is instantiated 4 times.
- Per-channel storage is register arrays. The decrementer, compare-to-1 logic and reload mux are single shared instances indexed by `ChIdx`.

## Test plan
- Reset mid-sweep: assert `ResetN` low while `ChIdx = 2` → all outputs 0, IDLE, and no `Expire` after release.
- Ch0 periodic, Src = 0, Reload = 3, with ten 1 ms strobes → `Expire[0]` on ticks 3, 6 and 9, each one cycle wide at k+4. `Running[0]` stays 1.
- Ch1 one-shot, Src = 3, Reload = 2 → `Expire[1]` once on the 2nd 1 s strobe, then `Running[1] = 0`. A 3rd strobe gives no pulse.
- 1 ms and 16 ms strobes in the same LPC cycle, with ch0 on Src 0 (Reload 1) and ch2 on Src 1 (Reload 1) → one sweep, and both expire at k+4 and k+6 respectively.
- CfgWr to ch1 with Reload = 5 in the cycle ch1 is visited (`Count = 1`) → no `Expire`, `Count = 5`.
- Write Enable = 0 to a running channel, and separately Reload = 0 → `Running` drops the next cycle with no `Expire` on subsequent ticks.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared encodings for the timer scheduler: tick source numbering, sweep
// states and the bit positions of the fields inside a configuration word.
package timer_sched_pkg;

  localparam logic [1:0] SRC_1MS   = 2'd0;
  localparam logic [1:0] SRC_16MS  = 2'd1;
  localparam logic [1:0] SRC_125MS = 2'd2;
  localparam logic [1:0] SRC_1S    = 2'd3;

  typedef enum logic {IDLE, SWEEP} state_t;

  function automatic int cfgEnableBit(input int cntW);
    return cntW + 3;
  endfunction

  function automatic int cfgPeriodicBit(input int cntW);
    return cntW + 2;
  endfunction

  function automatic int cfgSrcLsb(input int cntW);
    return cntW;
  endfunction

endpackage

// File: rtl/timer_scheduler_strobe_sync.sv
// Brings one slow-clock strobe into the LPC domain and turns its rising edge
// into a single-cycle tick.
module strobe_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_strobe,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_strobe;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel timer: synchronized strobe ticks are gathered into a pending
// set, then one shared decrementer sweeps every channel, one per cycle.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              LpcClock,
  input  logic              ResetN,
  input  logic              Strobe1ms,
  input  logic              Strobe16ms,
  input  logic              Strobe125ms,
  input  logic              Strobe1s,
  input  logic              CfgWr,
  input  logic [IDX_W-1:0]  CfgAddr,
  input  logic [CNT_W+3:0]  CfgData,
  output logic [NUM_CH-1:0] Expire,
  output logic [NUM_CH-1:0] Running
);

  localparam int EN_B  = cfgEnableBit(CNT_W);
  localparam int PER_B = cfgPeriodicBit(CNT_W);
  localparam int SRC_L = cfgSrcLsb(CNT_W);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  logic [3:0]       w_tick;
  state_t           r_state;
  logic [IDX_W-1:0] r_chIdx;
  logic [3:0]       r_pending;
  logic [3:0]       r_activeSrc;
  logic [CNT_W-1:0] r_count  [NUM_CH];
  logic [CNT_W-1:0] r_reload [NUM_CH];
  logic [1:0]       r_src    [NUM_CH];
  logic [NUM_CH-1:0] r_periodic;
  logic [NUM_CH-1:0] r_running;
  logic [NUM_CH-1:0] r_fresh;
  logic [NUM_CH-1:0] r_expire;

  strobe_sync u_sync1ms   (.i_clk(LpcClock), .i_reset_n(ResetN), .i_strobe(Strobe1ms),   .o_tick(w_tick[SRC_1MS]));
  strobe_sync u_sync16ms  (.i_clk(LpcClock), .i_reset_n(ResetN), .i_strobe(Strobe16ms),  .o_tick(w_tick[SRC_16MS]));
  strobe_sync u_sync125ms (.i_clk(LpcClock), .i_reset_n(ResetN), .i_strobe(Strobe125ms), .o_tick(w_tick[SRC_125MS]));
  strobe_sync u_sync1s    (.i_clk(LpcClock), .i_reset_n(ResetN), .i_strobe(Strobe1s),    .o_tick(w_tick[SRC_1S]));

  logic             w_cfgEn;
  logic             w_cfgPer;
  logic [1:0]       w_cfgSrc;
  logic [CNT_W-1:0] w_cfgReload;
  logic             w_addrOk;
  logic             w_start;
  logic             w_cfgHit;
  logic             w_visit;
  logic [CNT_W-1:0] w_curCount;
  logic             w_atOne;
  logic [CNT_W-1:0] w_nextCount;

  assign w_cfgEn     = CfgData[EN_B];
  assign w_cfgPer    = CfgData[PER_B];
  assign w_cfgSrc    = CfgData[SRC_L+1:SRC_L];
  assign w_cfgReload = CfgData[CNT_W-1:0];
  assign w_addrOk    = (32'(CfgAddr) < NUM_CH);
  assign w_start     = (r_state == IDLE) && (r_pending != 4'b0);

  // A config write to the channel under visit takes precedence over its decrement.
  assign w_cfgHit    = CfgWr && (CfgAddr == r_chIdx);
  assign w_visit     = (r_state == SWEEP) && r_running[r_chIdx] &&
                       r_activeSrc[r_src[r_chIdx]] && !r_fresh[r_chIdx] && !w_cfgHit;
  assign w_curCount  = r_count[r_chIdx];
  assign w_atOne     = (w_curCount == CNT_W'(1));
  assign w_nextCount = w_atOne ? r_reload[r_chIdx] : (w_curCount - CNT_W'(1));

  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= IDLE;
      r_chIdx     <= '0;
      r_pending   <= '0;
      r_activeSrc <= '0;
      r_periodic  <= '0;
      r_running   <= '0;
      r_fresh     <= '0;
      r_expire    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i]  <= '0;
        r_reload[i] <= '0;
        r_src[i]    <= '0;
      end
    end else begin
      r_expire  <= '0;
      r_pending <= (w_start ? 4'b0 : r_pending) | w_tick;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= SWEEP;
            r_activeSrc <= r_pending;
            r_chIdx     <= '0;
          end
        end
        SWEEP: begin
          if (r_chIdx == LAST_CH) begin
            r_state <= IDLE;
            r_chIdx <= '0;
          end else begin
            r_chIdx <= r_chIdx + 1'b1;
          end
        end
      endcase

      if (w_visit) begin
        r_count[r_chIdx] <= w_nextCount;
        if (w_atOne) begin
          r_expire[r_chIdx] <= 1'b1;
          if (!r_periodic[r_chIdx]) r_running[r_chIdx] <= 1'b0;
        end
      end

      if (CfgWr && w_addrOk) begin
        r_fresh[CfgAddr] <= 1'b1;
        if (w_cfgEn && (w_cfgReload != '0)) begin
          r_periodic[CfgAddr] <= w_cfgPer;
          r_src[CfgAddr]      <= w_cfgSrc;
          r_reload[CfgAddr]   <= w_cfgReload;
          r_count[CfgAddr]    <= w_cfgReload;
          r_running[CfgAddr]  <= 1'b1;
        end else begin
          r_running[CfgAddr]  <= 1'b0;
        end
      end

      // Newly written channels wait for the next sweep before counting.
      if (w_start) r_fresh <= '0;
    end
  end

  assign Expire  = r_expire;
  assign Running = r_running;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural channel model.
module tb_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int WIN    = NUM_CH + 7;

  logic              LpcClock = 1'b0;
  logic              ResetN;
  logic              Strobe1ms, Strobe16ms, Strobe125ms, Strobe1s;
  logic              CfgWr;
  logic [1:0]        CfgAddr;
  logic [CNT_W+3:0]  CfgData;
  logic [NUM_CH-1:0] Expire;
  logic [NUM_CH-1:0] Running;

  int checks = 0;
  int failures = 0;

  bit mRun [NUM_CH];
  bit mPer [NUM_CH];
  int mSrc [NUM_CH];
  int mCnt [NUM_CH];
  int mRel [NUM_CH];
  int obsExp [NUM_CH];

  timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .LpcClock(LpcClock), .ResetN(ResetN),
    .Strobe1ms(Strobe1ms), .Strobe16ms(Strobe16ms),
    .Strobe125ms(Strobe125ms), .Strobe1s(Strobe1s),
    .CfgWr(CfgWr), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .Expire(Expire), .Running(Running)
  );

  always #15 LpcClock = ~LpcClock;

  task automatic setStrobes(input logic [3:0] m);
    Strobe1ms   = m[0];
    Strobe16ms  = m[1];
    Strobe125ms = m[2];
    Strobe1s    = m[3];
  endtask

  task automatic modelClear();
    for (int i = 0; i < NUM_CH; i++) begin
      mRun[i] = 0; mPer[i] = 0; mSrc[i] = 0; mCnt[i] = 0; mRel[i] = 0; obsExp[i] = 0;
    end
  endtask

  function automatic logic [NUM_CH-1:0] modelRunVec();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = mRun[i];
    return v;
  endfunction

  task automatic modelCfg(input int ch, input logic en, input logic per, input logic [1:0] src, input int rel);
    if (en && rel != 0) begin
      mPer[ch] = per; mSrc[ch] = src; mRel[ch] = rel; mCnt[ch] = rel; mRun[ch] = 1;
    end else begin
      mRun[ch] = 0;
    end
  endtask

  // One tick event: every running channel on an active source loses one tick.
  task automatic modelSweep(input logic [3:0] act, output logic [NUM_CH-1:0] expv);
    expv = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mRun[i] && act[mSrc[i]]) begin
        if (mCnt[i] == 1) begin
          expv[i] = 1'b1;
          if (mPer[i]) mCnt[i] = mRel[i];
          else mRun[i] = 0;
        end else begin
          mCnt[i] = mCnt[i] - 1;
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge LpcClock);
    ResetN = 1'b0; CfgWr = 1'b0; setStrobes(4'b0);
    @(negedge LpcClock);
    ResetN = 1'b1;
    modelClear();
  endtask

  task automatic cfgWrite(input int ch, input logic en, input logic per, input logic [1:0] src, input int rel);
    @(negedge LpcClock);
    CfgWr = 1'b1; CfgAddr = 2'(ch); CfgData = {en, per, src, CNT_W'(rel)};
    @(negedge LpcClock);
    CfgWr = 1'b0;
    modelCfg(ch, en, per, src, rel);
    checks++;
    if (Running !== modelRunVec()) begin
      failures++;
      $display("[TB] FAIL cfg_running ch%0d: got %b expected %b", ch, Running, modelRunVec());
    end
  endtask

  // Pulse the strobes in mask m before edge k, then check Expire for each cycle after k.
  task automatic runEvent(input logic [3:0] m);
    logic [NUM_CH-1:0] expv;
    logic [NUM_CH-1:0] expNow;
    if (m != 4'b0) modelSweep(m, expv);
    else expv = '0;
    @(negedge LpcClock);
    setStrobes(m);
    for (int d = 0; d < WIN; d++) begin
      @(negedge LpcClock);
      if (d == 2) setStrobes(4'b0);
      expNow = '0;
      if (d >= 4 && d < 4 + NUM_CH && expv[d-4]) expNow[d-4] = 1'b1;
      for (int i = 0; i < NUM_CH; i++) obsExp[i] += int'(Expire[i]);
      checks++;
      if (Expire !== expNow) begin
        failures++;
        $display("[TB] FAIL expire mask=%b k+%0d: got %b expected %b", m, d, Expire, expNow);
      end
    end
    checks++;
    if (Running !== modelRunVec()) begin
      failures++;
      $display("[TB] FAIL running after mask=%b: got %b expected %b", m, Running, modelRunVec());
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b1; CfgWr = 1'b0; CfgAddr = '0; CfgData = '0; setStrobes(4'b0);
    #5 ResetN = 1'b0;
    repeat (2) @(negedge LpcClock);
    checks++;
    if (Expire !== '0) begin failures++; $display("[TB] FAIL reset_expire: got %b expected 0", Expire); end
    checks++;
    if (Running !== '0) begin failures++; $display("[TB] FAIL reset_running: got %b expected 0", Running); end
    ResetN = 1'b1;
    modelClear();
  endtask

  task automatic test_periodic();
    doReset();
    cfgWrite(0, 1'b1, 1'b1, 2'd0, 3);
    for (int t = 0; t < 10; t++) runEvent(4'b0001);
    checks++;
    if (obsExp[0] != 3) begin failures++; $display("[TB] FAIL periodic_count: got %0d expected 3", obsExp[0]); end
    checks++;
    if (Running[0] !== 1'b1) begin failures++; $display("[TB] FAIL periodic_running: got %b expected 1", Running[0]); end
  endtask

  task automatic test_oneshot();
    doReset();
    cfgWrite(1, 1'b1, 1'b0, 2'd3, 2);
    for (int t = 0; t < 3; t++) runEvent(4'b1000);
    checks++;
    if (obsExp[1] != 1) begin failures++; $display("[TB] FAIL oneshot_count: got %0d expected 1", obsExp[1]); end
    checks++;
    if (Running[1] !== 1'b0) begin failures++; $display("[TB] FAIL oneshot_running: got %b expected 0", Running[1]); end
  endtask

  task automatic test_simultaneous();
    doReset();
    cfgWrite(0, 1'b1, 1'b1, 2'd0, 1);
    cfgWrite(2, 1'b1, 1'b1, 2'd1, 1);
    cfgWrite(1, 1'b1, 1'b1, 2'd0, 2);
    runEvent(4'b0011);
    runEvent(4'b0011);
  endtask

  task automatic test_cfg_collision();
    doReset();
    cfgWrite(1, 1'b1, 1'b0, 2'd0, 1);
    @(negedge LpcClock);
    setStrobes(4'b0001);
    for (int d = 0; d < WIN; d++) begin
      @(negedge LpcClock);
      if (d == 2) setStrobes(4'b0);
      if (d == 4) begin
        CfgWr = 1'b1; CfgAddr = 2'd1; CfgData = {1'b1, 1'b0, 2'd0, CNT_W'(5)};
      end
      if (d == 5) CfgWr = 1'b0;
      checks++;
      if (Expire !== '0) begin failures++; $display("[TB] FAIL collision_expire k+%0d: got %b expected 0", d, Expire); end
    end
    modelCfg(1, 1'b1, 1'b0, 2'd0, 5);
    checks++;
    if (Running[1] !== 1'b1) begin failures++; $display("[TB] FAIL collision_running: got %b expected 1", Running[1]); end
    for (int t = 0; t < 5; t++) runEvent(4'b0001);
    checks++;
    if (obsExp[1] != 1) begin failures++; $display("[TB] FAIL collision_reload: got %0d expected 1", obsExp[1]); end
  endtask

  task automatic test_disable();
    doReset();
    cfgWrite(3, 1'b1, 1'b1, 2'd2, 2);
    runEvent(4'b0100);
    cfgWrite(3, 1'b0, 1'b1, 2'd2, 2);
    runEvent(4'b0100);
    runEvent(4'b0100);
    cfgWrite(3, 1'b1, 1'b1, 2'd2, 3);
    runEvent(4'b0100);
    cfgWrite(3, 1'b1, 1'b1, 2'd2, 0);
    for (int t = 0; t < 3; t++) runEvent(4'b0100);
    checks++;
    if (obsExp[3] != 0) begin failures++; $display("[TB] FAIL disable_count: got %0d expected 0", obsExp[3]); end
  endtask

  task automatic test_reset_mid_sweep();
    doReset();
    for (int c = 0; c < NUM_CH; c++) cfgWrite(c, 1'b1, 1'b1, 2'd0, 1);
    @(negedge LpcClock);
    setStrobes(4'b0001);
    for (int d = 0; d < 6; d++) begin
      @(negedge LpcClock);
      if (d == 2) setStrobes(4'b0);
      if (d == 4) begin
        checks++;
        if (Expire !== 4'b0001) begin failures++; $display("[TB] FAIL midsweep_pre: got %b expected 0001", Expire); end
      end
    end
    ResetN = 1'b0;
    #1;
    checks++;
    if (Expire !== '0) begin failures++; $display("[TB] FAIL midsweep_expire: got %b expected 0", Expire); end
    checks++;
    if (Running !== '0) begin failures++; $display("[TB] FAIL midsweep_running: got %b expected 0", Running); end
    @(negedge LpcClock);
    ResetN = 1'b1;
    modelClear();
    for (int d = 0; d < 12; d++) begin
      @(negedge LpcClock);
      checks++;
      if (Expire !== '0) begin failures++; $display("[TB] FAIL midsweep_after %0d: got %b expected 0", d, Expire); end
    end
    runEvent(4'b0001);
  endtask

  task automatic test_random();
    doReset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        cfgWrite(int'($urandom_range(0, NUM_CH - 1)), ($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)));
      end else begin
        runEvent(4'($urandom_range(1, 15)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_simultaneous();
    test_cfg_collision();
    test_disable();
    test_random();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
